// File: rtl/sync_downcount_pkg.sv
// Shared types and parameter limits for the sync_downcount timer.
package sync_downcount_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MIN_DIV   = 1;

endpackage

// File: rtl/sync_downcount_if.sv
// Control/status bundle between a controller and the sync_downcount timer.
interface sync_downcount_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, en, reload,
    input  q, tc, busy
  );

  modport slave (
    input  load, load_val, en, reload,
    output q, tc, busy
  );
endinterface

// File: rtl/sync_downcount_tick_gen.sv
// Prescaler: emits a combinational tick on every DIV-th enabled cycle.
module sync_downcount_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick_c
);

  generate
    if (DIV <= 1) begin : g_bypass
      // Every enabled cycle is a tick; no prescaler state is needed.
      logic unused_tick;
      assign unused_tick = &{1'b0, clk, rst, clear};
      assign tick_c = en;
    end else begin : g_count
      localparam int unsigned CW = $clog2(DIV);

      logic [CW-1:0] cnt_q;

      assign tick_c = en && (cnt_q == CW'(DIV - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (en) begin
          cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sync_downcount.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and
// optional auto-reload for periodic operation.
module sync_downcount
  import sync_downcount_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  sync_downcount_if.slave  bus
);

  localparam int unsigned DIV_EFF = (DIV < MIN_DIV) ? MIN_DIV : DIV;
  localparam int unsigned W       = (WIDTH < MIN_WIDTH) ? MIN_WIDTH : WIDTH;

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   rreg_q, rreg_d;
  logic           tc_q, tc_d;
  logic           busy_q;
  logic           presc_en_c;
  logic           tick_c;

  // Prescaler only advances while running and not being reloaded.
  assign presc_en_c = bus.en && (state_q == RUN) && !bus.load;

  sync_downcount_tick_gen #(
    .DIV (DIV_EFF)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (presc_en_c),
    .clear  (bus.load),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      rreg_q  <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rreg_q  <= rreg_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
    end
  end

  // Load wins over a coincident tick; terminal tick either reloads or parks at 0.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rreg_d  = rreg_q;
    tc_d    = 1'b0;

    if (bus.load) begin
      q_d     = bus.load_val;
      rreg_d  = bus.load_val;
      state_d = (bus.load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (tick_c) begin
            if (q_q > W'(1)) begin
              q_d = q_q - W'(1);
            end else begin
              tc_d = 1'b1;
              if (bus.reload) begin
                q_d = rreg_q;
              end else begin
                q_d     = '0;
                state_d = IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sync_downcount.sv
// Directed bench for sync_downcount: one DIV=1 instance and one DIV=3 instance.
module tb_sync_downcount;

  logic clk;
  logic rst;
  int unsigned vectors;
  int unsigned miscompares;

  sync_downcount_if #(.WIDTH(4)) a ();
  sync_downcount_if #(.WIDTH(4)) b ();

  sync_downcount #(.WIDTH(4), .DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
  sync_downcount #(.WIDTH(4), .DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned seq3[3];

  initial begin
    vectors     = 0;
    miscompares = 0;
    seq3[0] = 2; seq3[1] = 1; seq3[2] = 3;

    // Reset dominates a pending load
    rst = 1'b1;
    a.load = 1'b1; a.load_val = 4'd7; a.en = 1'b0; a.reload = 1'b0;
    b.load = 1'b1; b.load_val = 4'd7; b.en = 1'b0; b.reload = 1'b0;
    repeat (2) begin
      step();
      check("rst_q", a.q, 0);
      check("rst_tc", a.tc, 0);
      check("rst_busy", a.busy, 0);
      check("rst_b_q", b.q, 0);
      check("rst_b_busy", b.busy, 0);
    end
    rst = 1'b0;
    a.load = 1'b0; b.load = 1'b0;
    a.en = 1'b1; b.en = 1'b1;
    repeat (2) begin
      step();
      check("post_rst_q", a.q, 0);
      check("post_rst_busy", a.busy, 0);
      check("post_rst_tc", a.tc, 0);
      check("post_rst_b_q", b.q, 0);
    end

    // One-shot count 5 -> 0
    a.en = 1'b0; b.en = 1'b0;
    a.load = 1'b1; a.load_val = 4'd5;
    step();
    a.load = 1'b0;
    check("os_load_q", a.q, 5);
    check("os_load_busy", a.busy, 1);
    check("os_load_tc", a.tc, 0);
    a.en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      step();
      check("os_q", a.q, i);
      check("os_tc", a.tc, (i == 0) ? 1 : 0);
      check("os_busy", a.busy, (i != 0) ? 1 : 0);
    end
    step();
    check("os_hold_q", a.q, 0);
    check("os_hold_tc", a.tc, 0);

    // Auto-reload period of 3
    a.reload = 1'b1;
    a.load = 1'b1; a.load_val = 4'd3;
    step();
    a.load = 1'b0;
    check("ar_load_q", a.q, 3);
    for (int i = 0; i < 7; i++) begin
      step();
      check("ar_q", a.q, seq3[i % 3]);
      check("ar_tc", a.tc, (seq3[i % 3] == 3) ? 1 : 0);
      check("ar_busy", a.busy, 1);
    end
    a.en = 1'b0; a.reload = 1'b0;

    // DIV=3 prescale with an enable gap mid-interval
    b.en = 1'b1;
    b.load = 1'b1; b.load_val = 4'd4;
    step();
    b.load = 1'b0;
    check("ps_load_q", b.q, 4);
    repeat (2) begin step(); check("ps_q4", b.q, 4); end
    step(); check("ps_q3", b.q, 3);
    repeat (2) begin step(); check("ps_q3h", b.q, 3); end
    step(); check("ps_q2", b.q, 2);
    step(); check("ps_q2a", b.q, 2);
    b.en = 1'b0;
    repeat (5) begin
      step();
      check("ps_frozen_q", b.q, 2);
      check("ps_frozen_tc", b.tc, 0);
    end
    b.en = 1'b1;
    step(); check("ps_resume_q2", b.q, 2);
    step(); check("ps_resume_q1", b.q, 1);
    repeat (2) begin step(); check("ps_q1h", b.q, 1); check("ps_q1h_tc", b.tc, 0); end
    step();
    check("ps_end_q", b.q, 0);
    check("ps_end_tc", b.tc, 1);
    check("ps_end_busy", b.busy, 0);
    b.en = 1'b0;

    // Load beats a coincident tick, then load of zero
    a.en = 1'b1;
    a.load = 1'b1; a.load_val = 4'd5;
    step();
    a.load = 1'b0;
    check("ld_q5", a.q, 5);
    step(); step(); step();
    check("ld_q2", a.q, 2);
    a.load = 1'b1; a.load_val = 4'd9;
    step();
    check("ld_q9", a.q, 9);
    check("ld_q9_tc", a.tc, 0);
    a.load_val = 4'd0;
    step();
    a.load = 1'b0;
    check("ld0_q", a.q, 0);
    check("ld0_busy", a.busy, 0);
    check("ld0_tc", a.tc, 0);
    step();
    check("ld0_hold_tc", a.tc, 0);

    // Reset mid-run beats load, then full-range count
    a.load = 1'b1; a.load_val = 4'd15;
    step();
    a.load = 1'b0;
    repeat (9) step();
    check("mr_q6", a.q, 6);
    rst = 1'b1; a.load = 1'b1; a.load_val = 4'd12;
    step();
    check("mr_rst_q", a.q, 0);
    check("mr_rst_busy", a.busy, 0);
    check("mr_rst_tc", a.tc, 0);
    rst = 1'b0; a.load_val = 4'd15;
    step();
    a.load = 1'b0;
    check("full_load_q", a.q, 15);
    for (int i = 14; i >= 0; i--) begin
      step();
      check("full_q", a.q, i);
      check("full_tc", a.tc, (i == 0) ? 1 : 0);
    end
    step();
    check("full_hold_q", a.q, 0);
    check("full_hold_busy", a.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
